// File: rtl/ami_spi_reader.sv
// ami_spi_reader: SPI master for the two AMI monitor chips.
// Runs one CSB-framed 24-bit full-duplex transfer per command and returns
// the last 16 bits captured on SDO.
//
// Ports:
//   sysClk, sysReset       clock, synchronous active-high reset
//   cmdValid / cmdReady    command handshake
//   cmdSel                 target chip (0 or 1)
//   cmdRW                  1 = read (data field forced to 0), 0 = write
//   cmdAddr, cmdData       7-bit register address, 16-bit write data
//   rspValid               one-cycle pulse when a transfer completes
//   rspData                captured SDO data, held until the next rspValid
//   busy                   high from accept until cmdReady returns
//   AMI_SPI_CLK/SDI/CSB    per-chip SCLK, MOSI, active-low chip select
//   AMI_SPI_SDO            per-chip MISO
module ami_spi_reader #(
    parameter int CLK_DIV    = 5,
    parameter int GAP_CYCLES = 10
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdSel,
    input  logic        cmdRW,
    input  logic [6:0]  cmdAddr,
    input  logic [15:0] cmdData,
    output logic        rspValid,
    output logic [15:0] rspData,
    output logic        busy,
    output logic [1:0]  AMI_SPI_CLK,
    output logic [1:0]  AMI_SPI_SDI,
    input  logic [1:0]  AMI_SPI_SDO,
    output logic [1:0]  AMI_SPI_CSB
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    state_t            state;
    logic              sel;
    logic [22:0]       tx_word;
    logic [15:0]       rx_word;
    logic [DIV_W-1:0]  div_cnt;
    logic              phase_hi;
    logic [4:0]        bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic [23:0]       next_word;
    logic [1:0]        cmd_mask;
    logic [1:0]        sel_mask;

    // Reads shift out zeros in the data field.
    assign next_word = {cmdRW, cmdAddr, cmdRW ? 16'h0000 : cmdData};

    // One-hot pin masks so the unselected chip never sees activity.
    assign cmd_mask = cmdSel ? 2'b10 : 2'b01;
    assign sel_mask = sel ? 2'b10 : 2'b01;

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            tx_word     <= '0;
            rx_word     <= '0;
            div_cnt     <= '0;
            phase_hi    <= 1'b0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            cmdReady    <= 1'b1;
            busy        <= 1'b0;
            rspValid    <= 1'b0;
            rspData     <= '0;
            AMI_SPI_CLK <= 2'b00;
            AMI_SPI_SDI <= 2'b00;
            AMI_SPI_CSB <= 2'b11;
        end else begin
            rspValid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cmdValid && cmdReady) begin
                        sel         <= cmdSel;
                        tx_word     <= next_word[22:0];
                        rx_word     <= '0;
                        div_cnt     <= '0;
                        cmdReady    <= 1'b0;
                        busy        <= 1'b1;
                        AMI_SPI_CSB <= ~cmd_mask;
                        AMI_SPI_SDI <= next_word[23] ? cmd_mask : 2'b00;
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt     <= '0;
                        phase_hi    <= 1'b1;
                        bit_cnt     <= 5'd23;
                        AMI_SPI_CLK <= sel_mask;
                        state       <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (phase_hi) begin
                            // End of high phase: sample SDO, then present
                            // the next bit. Only the low 16 captured bits
                            // are ever reported, so older bits shift out.
                            rx_word     <= {rx_word[14:0], AMI_SPI_SDO[sel]};
                            AMI_SPI_CLK <= 2'b00;
                            AMI_SPI_SDI <= tx_word[22] ? sel_mask : 2'b00;
                            tx_word     <= {tx_word[21:0], 1'b0};
                            phase_hi    <= 1'b0;
                        end else if (bit_cnt == 5'd0) begin
                            // Final low phase doubles as CSB hold time.
                            AMI_SPI_CSB <= 2'b11;
                            AMI_SPI_SDI <= 2'b00;
                            rspValid    <= 1'b1;
                            rspData     <= rx_word;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            bit_cnt     <= bit_cnt - 1'b1;
                            AMI_SPI_CLK <= sel_mask;
                            phase_hi    <= 1'b1;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        cmdReady <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ami_spi_reader.md
Name: ami_spi_reader

Overview:
- SPI master for the two AMI monitor chips. It performs full-duplex 24-bit transactions and returns the 16-bit readback captured on AMI_SPI_SDO.
- It is the reading counterpart to the write-only AFE SPI path. It sits in the sysClk domain between the register-interface command FIFO and the AMI_SPI_* pins.
- Each command runs one complete CSB-framed transfer. A response pulse follows every transfer.

Parameters:
- CLK_DIV, 5, SCLK half-period in sysClk cycles; minimum 2. The default gives 10 MHz SCLK at 100 MHz sysClk.
- GAP_CYCLES, 10, minimum CSB-high time between transfers in sysClk cycles; minimum 1.

Ports:
- sysClk  in  1  system clock; all logic runs on it.
- sysReset  in  1  synchronous, active-high reset.
- cmdValid  in  1  command request.
- cmdReady  out  1  high when a command can be accepted.
- cmdSel  in  1  chip select index (0 or 1).
- cmdRW  in  1  1 = read, 0 = write.
- cmdAddr  in  7  register address.
- cmdData  in  16  write data; ignored for reads.
- rspValid  out  1  one-cycle pulse at the end of each transfer.
- rspData  out  16  captured SDO data; held until the next rspValid.
- busy  out  1  high from command accept until cmdReady returns high.
- AMI_SPI_CLK  out  2  SCLK per chip.
- AMI_SPI_SDI  out  2  MOSI per chip.
- AMI_SPI_SDO  in  2  MISO per chip.
- AMI_SPI_CSB  out  2  active-low chip select per chip.

Behaviour:
- Reset values: cmdReady=1, busy=0, rspValid=0, rspData=0, AMI_SPI_CSB=2'b11, AMI_SPI_CLK=0, AMI_SPI_SDI=0.
- Accept: a command is accepted on a cycle with cmdValid&&cmdReady. That cycle is called cycle 0.
  - cmdReady drops and busy rises in cycle 1.
  - cmdValid while cmdReady=0 is ignored; no queueing.
- Shift word, MSB first: {cmdRW, cmdAddr, cmdData}. For reads the data field is forced to 0.
- State machine: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- IDLE:
  - cmdReady=1.
  - On accept: latch sel and word, move to SETUP.
- SETUP:
  - Cycles 1..CLK_DIV.
  - CSB[sel]=0 from cycle 1; SDI[sel]=bit 23 from cycle 1; SCLK low.
- SHIFT: 24 SCLK periods. Each period is CLK_DIV cycles high, then CLK_DIV cycles low.
  - SDO[sel] is sampled on the last sysClk cycle of each high phase and shifted into a 24-bit capture register LSB-in.
  - SDI updates on the first cycle of each low phase with the next bit.
  - After bit 0 the SDI value during the final low phase is don't-care; drive 0.
  - The final low phase provides CSB hold time.
- End of transfer, at cycle 1+49*CLK_DIV:
  - CSB[sel] returns to 1.
  - rspValid pulses for one cycle.
  - rspData = capture[15:0]. This also happens for writes.
  - Go to GAP.
- GAP:
  - CSB high for GAP_CYCLES cycles.
  - Then cmdReady=1 and busy=0, enter IDLE.
  - With defaults, cmdReady returns at cycle 256.
- Unselected chip: CSB=1, CLK=0, SDI=0 throughout. Its SDO is ignored.
- Counters:
  - Half-period counter ceil(log2(CLK_DIV)) bits, wrapping at CLK_DIV-1.
  - Bit counter 5 bits, 23 down to 0.
  - Gap counter sized for GAP_CYCLES.
- cmdValid held continuously: back-to-back transfers, each separated by exactly GAP_CYCLES CSB-high cycles.
- sysReset mid-transfer:
  - Next cycle CSB=2'b11, CLK=0, SDI=0, state IDLE.
  - The command is dropped; no rspValid. rspData is cleared to 0.
- sysReset on the accept cycle: reset wins; the command is not accepted.
- All outputs are registered; no combinational path from inputs to pins.

Test Plan:
- Write: sel=0, RW=0, addr=0x15, data=0x1234.
  - CSB[0] falls at cycle 1 and rises at cycle 246.
  - SDI shows 0x151234 MSB first across 24 SCLK rising edges.
  - SCLK is 10 cycles per period; rspValid pulses at cycle 246; cmdReady returns at cycle 256.
- Read: sel=1, RW=1, addr=0x42.
  - An SDO model drives 0xA55A during the last 16 bits.
  - SDI word is 0xC20000; rspData=0xA55A at rspValid.
  - CSB[0], CLK[0] and SDI[0] stay idle the whole time.
- cmdValid held high for 3 commands:
  - Exactly 3 rspValid pulses.
  - CSB high gap between transfers is exactly 10 cycles.
  - No command is accepted while busy.
- sysReset asserted at cycle 100 of a read:
  - Cycle 101: CSB=11, CLK=0, cmdReady=1, rspData=0, and no rspValid.
  - A following read completes normally.
- CLK_DIV=2, GAP_CYCLES=1:
  - Read returns the SDO pattern 0xFFFF then 0x0001 correctly.
  - CSB low duration is 98 cycles.
